// File: rtl/feat_bram_reader.sv
// rtl/feat_bram_reader.sv - streams the new-feature BRAM onto a valid/ready stream
// Credit-based issue keeps BRAM reads in flight plus buffered beats within the output FIFO.
module feat_bram_reader #(
  parameter int NEW_FEATURE_WIDTH = 32,
  parameter int NUM_SUBGRAPHS     = 2708,
  parameter int NUM_FEATURE_OUT   = 16,
  parameter int BRAM_LATENCY      = 2,
  parameter int FIFO_DEPTH        = 4,
  localparam int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  localparam int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic [NEW_FEATURE_ADDR_W:0]   beat_count
);

  localparam int AW    = NEW_FEATURE_ADDR_W;
  localparam int COL_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1) + 1;

  localparam logic [AW-1:0]    LAST_IDX  = AW'(NEW_FEATURE_DEPTH - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(NUM_FEATURE_OUT - 1);
  localparam logic [AW:0]      BEATS_MAX = (AW + 1)'(NEW_FEATURE_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;

  logic [AW-1:0]    addr_q, next_idx, cur_idx;
  logic [COL_W-1:0] next_col, cur_col;
  logic             credit, issue, tag_last, tag_user;

  logic [BRAM_LATENCY-1:0] pipe_vld, pipe_last, pipe_user;
  logic [CNT_W-1:0]        inflight, fifo_count;

  logic [NEW_FEATURE_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]        fifo_last, fifo_user;
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic                         push, pop, fifo_empty;

  // Word 0 is issued on the start edge itself, so IDLE presents index 0.
  assign cur_idx  = (state == IDLE) ? '0 : next_idx;
  assign cur_col  = (state == IDLE) ? '0 : next_col;
  assign tag_last = (cur_col == LAST_COL);
  assign tag_user = (cur_idx == LAST_IDX);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) begin
      inflight = inflight + CNT_W'(pipe_vld[i]);
    end
  end

  assign credit = (inflight + fifo_count) < CNT_W'(FIFO_DEPTH);
  assign issue  = ((state == IDLE) && start) || ((state == RUN) && credit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      next_idx <= '0;
      next_col <= '0;
    end else if (issue) begin
      addr_q   <= cur_idx;
      next_idx <= cur_idx + AW'(1);
      next_col <= tag_last ? '0 : cur_col + COL_W'(1);
    end
  end

  assign feat_bram_addrb = {addr_q, 2'b00};

  // Tag pipe mirrors the BRAM read latency; its tail marks when dout is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
      pipe_user <= '0;
    end else begin
      pipe_vld[0]  <= issue;
      pipe_last[0] <= tag_last;
      pipe_user[0] <= tag_user;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
        pipe_user[i] <= pipe_user[i-1];
      end
    end
  end

  assign push       = pipe_vld[BRAM_LATENCY-1];
  assign fifo_empty = (fifo_count == '0);
  assign pop        = !fifo_empty && m_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_last  <= '0;
      fifo_user  <= '0;
    end else begin
      if (push) begin
        wr_ptr            <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
        fifo_last[wr_ptr] <= pipe_last[BRAM_LATENCY-1];
        fifo_user[wr_ptr] <= pipe_user[BRAM_LATENCY-1];
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (!push && pop) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= feat_bram_dout;
    end
  end

  // Head outputs are gated so an empty FIFO presents zeros, including after reset.
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_data[rd_ptr];
  assign m_axis_tlast  = !fifo_empty && fifo_last[rd_ptr];
  assign m_axis_tuser  = !fifo_empty && fifo_user[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count <= '0;
    end else if ((state == IDLE) && start) begin
      beat_count <= '0;
    end else if (pop && (beat_count != BEATS_MAX)) begin
      beat_count <= beat_count + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = tag_user ? DRAIN : RUN;
      RUN:     if (issue && tag_user) state_nx = DRAIN;
      DRAIN:   if (pop && m_axis_tuser) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DRAIN) && pop && m_axis_tuser;
  end

endmodule

// File: tb/tb_feat_bram_reader.sv
// tb/tb_feat_bram_reader.sv - directed self-checking bench for feat_bram_reader
module tb_feat_bram_reader;

  localparam int W     = 32;
  localparam int NS    = 3;
  localparam int NOF   = 4;
  localparam int LAT   = 2;
  localparam int FD    = 4;
  localparam int DEPTH = NS * NOF;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          tready = 1'b0;
  logic          busy, done, tvalid, tlast, tuser;
  logic [AW+1:0] addrb;
  logic [W-1:0]  dout, tdata;
  logic [AW:0]   beat_count;

  int total = 0;
  int bad = 0;
  int cyc, mode, done_cnt, done_cyc, busy_fall, max_fifo;
  bit ghost;
  logic prev_stall, prev_last, prev_user;
  logic [W-1:0] prev_data;
  logic [W-1:0] q_data[$];
  logic q_last[$];
  logic q_user[$];
  int   q_cyc[$];
  int   q_addr[$];

  feat_bram_reader #(
    .NEW_FEATURE_WIDTH(W), .NUM_SUBGRAPHS(NS), .NUM_FEATURE_OUT(NOF),
    .BRAM_LATENCY(LAT), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .feat_bram_addrb(addrb), .feat_bram_dout(dout),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .m_axis_tuser(tuser), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  // BRAM model: registered address plus one read stage gives a latency of 2.
  always @(posedge clk) dout <= 32'hA000_0000 + 32'(addrb >> 2);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic ready_for(input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
      default: return c > 20;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    tready = ready_for(cyc);
    start  = ghost && (cyc == 5 || cyc == 13);
    if (prev_stall) begin
      chk("hold_valid", 64'(tvalid), 64'(1));
      chk("hold_data", 64'(tdata), 64'(prev_data));
      chk("hold_flags", 64'({tlast, tuser}), 64'({prev_last, prev_user}));
    end
    if (tvalid && tready) begin
      q_data.push_back(tdata);
      q_last.push_back(tlast);
      q_user.push_back(tuser);
      q_cyc.push_back(cyc);
    end
    prev_stall = tvalid && !tready;
    prev_data  = tdata;
    prev_last  = tlast;
    prev_user  = tuser;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy && (q_addr.size() == 0 || int'(addrb) != q_addr[$])) q_addr.push_back(int'(addrb));
    if (int'(dut.fifo_count) > max_fifo) max_fifo = int'(dut.fifo_count);
  endtask

  task automatic clear_logs();
    q_data.delete(); q_last.delete(); q_user.delete(); q_cyc.delete(); q_addr.delete();
    done_cnt = 0; done_cyc = -1; busy_fall = -1; max_fifo = 0; prev_stall = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_addr"}, 64'(addrb), 64'(0));
    chk({tag, "_valid"}, 64'(tvalid), 64'(0));
    chk({tag, "_data"}, 64'(tdata), 64'(0));
    chk({tag, "_flags"}, 64'({tlast, tuser}), 64'(0));
    chk({tag, "_beats"}, 64'(beat_count), 64'(0));
  endtask

  task automatic run_frame(input int m, input bit ghost_en);
    mode = m; ghost = ghost_en; cyc = 0;
    clear_logs();
    start = 1'b1; tready = 1'b0;
    step();
    chk("busy_c1", 64'(busy), 64'(1));
    chk("addr_c1", 64'(addrb), 64'(0));
    for (int i = 0; i < 300; i++) begin
      step();
      if (mode == 2 && cyc == 20) begin
        chk("stall_addr", 64'(addrb), 64'h0C);
        chk("stall_fill", 64'(dut.fifo_count), 64'(4));
        chk("stall_valid", 64'(tvalid), 64'(1));
      end
      if (!busy) begin
        busy_fall = cyc;
        break;
      end
    end
    chk("frame_timeout", 64'(busy_fall > 0), 64'(1));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_after", 64'(busy), 64'(0));
    end
    chk("beats_n", 64'(q_data.size()), 64'(DEPTH));
    for (int i = 0; i < DEPTH && i < q_data.size(); i++) begin
      chk("beat_data", 64'(q_data[i]), 64'(32'hA000_0000 + i));
      chk("beat_last", 64'(q_last[i]), 64'(i % NOF == NOF - 1));
      chk("beat_user", 64'(q_user[i]), 64'(i == DEPTH - 1));
      if (mode == 0) chk("beat_cyc", 64'(q_cyc[i]), 64'(3 + i));
    end
    chk("addr_n", 64'(q_addr.size()), 64'(DEPTH));
    for (int i = 0; i < DEPTH && i < q_addr.size(); i++) begin
      chk("addr_seq", 64'(q_addr[i]), 64'(4 * i));
      chk("addr_lsb", 64'(q_addr[i] & 3), 64'(0));
    end
    chk("done_once", 64'(done_cnt), 64'(1));
    chk("beat_count", 64'(beat_count), 64'(DEPTH));
    chk("fifo_max", 64'(max_fifo <= FD), 64'(1));
    if (mode == 0) begin
      chk("done_cyc", 64'(done_cyc), 64'(14));
      chk("busy_fall", 64'(busy_fall), 64'(15));
    end
  endtask

  initial begin
    #1;
    check_reset_outputs("rst0");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_frame(0, 1'b0);
    run_frame(1, 1'b0);
    run_frame(2, 1'b0);
    run_frame(0, 1'b1);

    // Abort a frame after five beats with an asynchronous reset.
    mode = 0; ghost = 1'b0; cyc = 0;
    clear_logs();
    start = 1'b1;
    step();
    for (int i = 0; i < 50; i++) begin
      step();
      if (q_data.size() >= 5) break;
    end
    chk("pre_reset_beats", 64'(q_data.size()), 64'(5));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_valid", 64'(tvalid), 64'(0));
      chk("post_rst_busy", 64'(busy), 64'(0));
    end
    run_frame(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/feat_bram_reader.md
# feat_bram_reader

Readback engine on the output side of the GAT accelerator. It drives the byte-addressed read port of the new-feature BRAM (`feat_bram_addrb` / `feat_bram_dout`) and absorbs the BRAM's fixed read latency. It streams every output-feature word, in address order, onto a valid/ready stream with per-node and end-of-frame markers. It sits between `gat_top_wrapper` and the host-side DMA/stream sink, and is launched once `gat_ready` indicates results are complete.

## Interface

Parameters:
- `NEW_FEATURE_WIDTH`, 32, word width of the feature BRAM and of the stream.
- `NUM_SUBGRAPHS`, 2708, number of nodes (rows) to read.
- `NUM_FEATURE_OUT`, 16, words per node; `m_axis_tlast` marks the last word of each node.
- `BRAM_LATENCY`, 2, cycles from `feat_bram_addrb` change to matching `feat_bram_dout`. Must be ≥ 1.
- `FIFO_DEPTH`, 4, output buffer entries. Must satisfy `FIFO_DEPTH` ≥ `BRAM_LATENCY`+2.
- `NEW_FEATURE_DEPTH`, `NUM_SUBGRAPHS*NUM_FEATURE_OUT`, total words (local).
- `NEW_FEATURE_ADDR_W`, `$clog2(NEW_FEATURE_DEPTH)`, word-address width (local).

Ports:
- `clk`, in, 1: single clock for everything.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle launch pulse; sampled only in IDLE.
- `busy`, out, 1: high in RUN and DRAIN.
- `done`, out, 1: one-cycle pulse when the final beat has been accepted.
- `feat_bram_addrb`, out, `NEW_FEATURE_ADDR_W+2`: byte address = word index << 2; bits [1:0] always 0.
- `feat_bram_dout`, in, `NEW_FEATURE_WIDTH`: BRAM read data. The port is always enabled.
- `m_axis_tdata`, out, `NEW_FEATURE_WIDTH`: stream data.
- `m_axis_tvalid`, out, 1: stream valid.
- `m_axis_tready`, in, 1: stream ready.
- `m_axis_tlast`, out, 1: last word of the current node (word index mod `NUM_FEATURE_OUT` = `NUM_FEATURE_OUT`−1).
- `m_axis_tuser`, out, 1: last word of the frame (word index = `NEW_FEATURE_DEPTH`−1).
- `beat_count`, out, `NEW_FEATURE_ADDR_W+1`: number of beats accepted since the last `start`.

## Operation

- **FSM: IDLE → RUN → DRAIN → IDLE.**
  - IDLE → RUN on `start`=1.
  - RUN → DRAIN in the cycle the last word index is issued.
  - DRAIN → IDLE when the last beat is accepted. `done`=1 in that same cycle.
  - `start` in any state other than IDLE is ignored.
- **Issue.** The issue counter runs from 0 to `NEW_FEATURE_DEPTH`−1. One word is issued per cycle in RUN when `inflight + fifo_count < FIFO_DEPTH`, both values taken from the current cycle's registers.
  - The issue happens by presenting the new address on `feat_bram_addrb`. The address holds when no issue occurs.
  - Each issue pushes a tag into a `BRAM_LATENCY`-deep valid shift pipe. The tag holds the valid bit, tlast and tuser.
- **Capture.** When the tag emerges from the pipe, `feat_bram_dout` is written into the FIFO together with the tag's tlast and tuser. The credit check guarantees the FIFO never overflows.
- **FIFO.** Show-ahead.
  - `m_axis_tvalid` = FIFO not empty. Data, tlast and tuser come from the head entry.
  - Pop on `tvalid && tready`.
  - A simultaneous push and pop leaves the count unchanged.
- **Stream rules.**
  - Once `tvalid` is high, the data, tlast and tuser are stable until the beat is accepted.
  - `tvalid` never drops without acceptance.
- **`beat_count`.** Cleared on an accepted `start`; increments on each accepted beat; saturates at `NEW_FEATURE_DEPTH`.
- **Reset.** Reset mid-operation aborts the frame immediately:
  - FIFO and pipe are flushed; no stale beat is emitted after release.
  - State returns to IDLE.
- **Output reset values.** `busy`=0, `done`=0, `feat_bram_addrb`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `beat_count`=0.

## Timing

- `start` is sampled high at edge 0. `busy`=1 and `feat_bram_addrb`=0 are visible from cycle 1.
- Data for address A, presented in cycle c, is captured at the end of cycle c+`BRAM_LATENCY`−1 and appears on the stream at cycle c+`BRAM_LATENCY`.
- First `m_axis_tvalid` is at cycle 1+`BRAM_LATENCY`.
- With `tready` held at 1 throughout, the block streams one beat per cycle with no bubbles. The last beat is at cycle `BRAM_LATENCY`+`NEW_FEATURE_DEPTH`, and `done` pulses in that same cycle. `busy` falls the cycle after.
- Under backpressure, issue stalls within one cycle of the FIFO plus in-flight count reaching `FIFO_DEPTH`. Issue resumes the cycle after a pop frees a credit.
- A new `start` is accepted no earlier than the cycle after `done`.

## Test plan

Bench parameters: `NUM_SUBGRAPHS`=3, `NUM_FEATURE_OUT`=4, `BRAM_LATENCY`=2, `FIFO_DEPTH`=4. The BRAM model returns `0xA0000000` + word index, with the stated latency.

- **Full throughput.** `start` with `tready`=1 → 12 consecutive beats `0xA0000000`..`0xA000000B` at cycles 3..14. `tlast` on words 3, 7 and 11; `tuser` only on word 11. `done` pulses at cycle 14; `beat_count`=12.
- **Backpressure.** `tready` toggles 1,0,0,1 repeating → the same 12 values in order with no duplicates or drops. Data is stable while stalled, and the FIFO never exceeds 4 entries.
- **Long stall.** `tready`=0 for 20 cycles after `start` → the address advances no further than word 3 and exactly 4 entries are buffered. After release, all 12 words arrive in order.
- **Start while busy.** A second `start` pulse in RUN and again in DRAIN → ignored. The frame completes once and `done` pulses once.
- **Reset mid-frame.** Assert `rst_n`=0 after 5 beats → all outputs take their reset values immediately. A subsequent `start` replays from word 0 (`0xA0000000`).
- **Byte addressing.** Check the address sequence on `feat_bram_addrb` → 0x00, 0x04, …, 0x2C, with bits [1:0] always 0.
